// File: rtl/esm_pkg.sv
// Shared constants and types for the ESM instruction-buffer write path.
// Slot masks are ascending ([0:N-1]) so slot 0 is the leftmost bit.
package esm_pkg;

   localparam int ESM_IW    = 32;
   localparam int ESM_BS    = 16;
   localparam int ESM_IDX_W = $clog2(ESM_BS);
   localparam int ESM_OCC_W = ESM_IDX_W + 1;

   typedef logic [0:ESM_BS-1]    esm_slot_mask_t;
   typedef logic [ESM_IDX_W-1:0] esm_slot_idx_t;
   typedef logic [ESM_OCC_W-1:0] esm_occ_t;

endpackage : esm_pkg

// File: rtl/esm_free_slot_picker.sv
// Lowest-index free-slot finder: returns the first slot whose mask bit is 0.
module esm_free_slot_picker
   import esm_pkg::*;
#(
   parameter int bs = ESM_BS
) (
   input  logic [0:bs-1]         mask,
   output logic [$clog2(bs)-1:0] index,
   output logic                  found
);

   localparam int IW = $clog2(bs);

   always_comb begin
      // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
      index = '0;
      found = 1'b0;
      for (int i = bs - 1; i >= 0; i--) begin
         if (!mask[i]) begin
            index = IW'(i);
            found = 1'b1;
         end
      end
   end

endmodule : esm_free_slot_picker

// File: rtl/esm_buffer_writer.sv
// Write-side front end of the ESM instruction buffer: slot allocation, release and core write strobe.
// Optional oldest-entry tracking is built when ESM_BUFFER_WRITER_AGE_EN is defined.
module esm_buffer_writer
   import esm_pkg::*;
#(
   parameter int Instruction_word_size = ESM_IW,
   parameter int bs                    = ESM_BS
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [Instruction_word_size-1:0] in_instr,
   input  logic                             in_regwrite,
   input  logic                             in_alusrc,
   input  logic                             flush,
   input  logic [0:bs-1]                    issue_mask,
   output logic                             wr_en,
   output logic [Instruction_word_size-1:0] Instr_in,
   output logic                             RegWrite,
   output logic                             ALUSrc,
   output logic [$clog2(bs)-1:0]            buffer_index,
   output logic [0:bs-1]                    valid_entries,
   output logic [$clog2(bs):0]              occupancy,
   output logic                             full,
   output logic                             empty
`ifdef ESM_BUFFER_WRITER_AGE_EN
   ,
   output logic                             oldest_valid,
   output logic [$clog2(bs)-1:0]            oldest_index
`endif
);

   localparam int IW = $clog2(bs);
   localparam int OW = IW + 1;

   logic [0:bs-1]                    valid_q, valid_d;
   logic [OW-1:0]                    occ_q, occ_d;
   logic                             wr_en_q, wr_en_d;
   logic [Instruction_word_size-1:0] instr_q, instr_d;
   logic                             regwrite_q, regwrite_d;
   logic                             alusrc_q, alusrc_d;
   logic [IW-1:0]                    idx_q, idx_d;

   logic [IW-1:0] free_idx;
   logic          free_found;
   logic          accept;
   logic [0:bs-1] released;
   logic [OW-1:0] rel_cnt;

   esm_free_slot_picker #(.bs(bs)) u_picker (
      .mask  (valid_q),
      .index (free_idx),
      .found (free_found)
   );

   assign full     = (occ_q == OW'(bs));
   assign empty    = (occ_q == '0);
   assign in_ready = rst & ~flush & ~full;
   assign accept   = in_valid & in_ready & free_found;

   // Only slots that are actually occupied count toward the occupancy decrement.
   assign released = valid_q & issue_mask;

   always_comb begin
      rel_cnt = '0;
      for (int i = 0; i < bs; i++) begin
         rel_cnt = rel_cnt + OW'(released[i]);
      end
   end

   always_comb begin
      valid_d    = valid_q & ~issue_mask;
      occ_d      = occ_q - rel_cnt;
      wr_en_d    = 1'b0;
      instr_d    = instr_q;
      regwrite_d = regwrite_q;
      alusrc_d   = alusrc_q;
      idx_d      = idx_q;
      if (accept) begin
         valid_d[free_idx] = 1'b1;
         occ_d             = occ_d + OW'(1);
         wr_en_d           = 1'b1;
         instr_d           = in_instr;
         regwrite_d        = in_regwrite;
         alusrc_d          = in_alusrc;
         idx_d             = free_idx;
      end
      if (flush) begin
         valid_d = '0;
         occ_d   = '0;
         wr_en_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      if (!rst) begin
         valid_q    <= '0;
         occ_q      <= '0;
         wr_en_q    <= 1'b0;
         instr_q    <= '0;
         regwrite_q <= 1'b0;
         alusrc_q   <= 1'b0;
         idx_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         occ_q      <= occ_d;
         wr_en_q    <= wr_en_d;
         instr_q    <= instr_d;
         regwrite_q <= regwrite_d;
         alusrc_q   <= alusrc_d;
         idx_q      <= idx_d;
      end
   end

   assign wr_en         = wr_en_q;
   assign Instr_in      = instr_q;
   assign RegWrite      = regwrite_q;
   assign ALUSrc        = alusrc_q;
   assign buffer_index  = idx_q;
   assign valid_entries = valid_q;
   assign occupancy     = occ_q;

`ifdef ESM_BUFFER_WRITER_AGE_EN
   // age_q[i][j] == 1 means slot j was allocated before slot i.
   logic [0:bs-1] age_q [bs];
   logic [0:bs-1] age_d [bs];
   logic          oldest_valid_q, oldest_valid_d;
   logic [IW-1:0] oldest_idx_q, oldest_idx_d;

   always_comb begin
      for (int i = 0; i < bs; i++) begin
         age_d[i] = age_q[i];
      end
      if (accept && !flush) begin
         for (int i = 0; i < bs; i++) begin
            age_d[i][free_idx] = 1'b0;
         end
         age_d[free_idx] = valid_q & ~issue_mask;
      end
   end

   always_comb begin
      oldest_valid_d = 1'b0;
      oldest_idx_d   = '0;
      for (int i = bs - 1; i >= 0; i--) begin
         if (valid_d[i] && ((age_d[i] & valid_d) == '0)) begin
            oldest_valid_d = 1'b1;
            oldest_idx_d   = IW'(i);
         end
      end
   end

   // NOTE: the age matrix has no reset; stale rows are masked by valid and columns clear on reallocation.
   always_ff @(posedge clk) begin
      for (int i = 0; i < bs; i++) begin
         age_q[i] <= age_d[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         oldest_valid_q <= 1'b0;
         oldest_idx_q   <= '0;
      end else begin
         oldest_valid_q <= oldest_valid_d;
         oldest_idx_q   <= oldest_idx_d;
      end
   end

   assign oldest_valid = oldest_valid_q;
   assign oldest_index = oldest_idx_q;
`endif

endmodule : esm_buffer_writer

// File: tb/tb_esm_buffer_writer.sv
// Directed bench for esm_buffer_writer: reset, single write, fill, release/reuse, same-cycle, flush, mid-run reset.
module tb_esm_buffer_writer;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        in_regwrite;
   logic        in_alusrc;
   logic        flush;
   logic [0:15] issue_mask;
   logic        wr_en;
   logic [31:0] Instr_in;
   logic        RegWrite;
   logic        ALUSrc;
   logic [3:0]  buffer_index;
   logic [0:15] valid_entries;
   logic [4:0]  occupancy;
   logic        full;
   logic        empty;
`ifdef ESM_BUFFER_WRITER_AGE_EN
   logic        oldest_valid;
   logic [3:0]  oldest_index;
`endif

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   esm_buffer_writer dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_instr      (in_instr),
      .in_regwrite   (in_regwrite),
      .in_alusrc     (in_alusrc),
      .flush         (flush),
      .issue_mask    (issue_mask),
      .wr_en         (wr_en),
      .Instr_in      (Instr_in),
      .RegWrite      (RegWrite),
      .ALUSrc        (ALUSrc),
      .buffer_index  (buffer_index),
      .valid_entries (valid_entries),
      .occupancy     (occupancy),
      .full          (full),
      .empty         (empty)
`ifdef ESM_BUFFER_WRITER_AGE_EN
      ,
      .oldest_valid  (oldest_valid),
      .oldest_index  (oldest_index)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b0;
      in_valid    = 1'b1;
      in_instr    = 32'hDEAD_BEEF;
      in_regwrite = 1'b1;
      in_alusrc   = 1'b1;
      flush       = 1'b0;
      issue_mask  = '0;

      // Reset held two cycles with a beat offered.
      step();
      step();
      check("rst_valid", valid_entries, 16'h0000);
      check("rst_occ", occupancy, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_wr_en", wr_en, 0);
      check("rst_ready", in_ready, 0);
      check("rst_instr", Instr_in, 0);
      check("rst_idx", buffer_index, 0);

      // Single write.
      rst         = 1'b1;
      in_instr    = 32'h00A3_0233;
      in_regwrite = 1'b1;
      in_alusrc   = 1'b0;
      #1;
      check("w1_ready", in_ready, 1);
      step();
      in_valid = 1'b0;
      check("w1_wr_en", wr_en, 1);
      check("w1_idx", buffer_index, 0);
      check("w1_valid", valid_entries, 16'h8000);
      check("w1_occ", occupancy, 1);
      check("w1_instr", Instr_in, 32'h00A3_0233);
      check("w1_regwrite", RegWrite, 1);
      check("w1_alusrc", ALUSrc, 0);
      step();
      check("w1_strobe_drop", wr_en, 0);
      check("w1_hold", Instr_in, 32'h00A3_0233);

      // Empty the buffer, then 16 back-to-back beats.
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("pre_fill_occ", occupancy, 0);
      for (int k = 0; k < 16; k++) begin
         in_valid    = 1'b1;
         in_instr    = 32'h1000_0000 + k;
         in_alusrc   = k[0];
         in_regwrite = ~k[0];
         step();
         check($sformatf("fill_idx%0d", k), buffer_index, k);
         check($sformatf("fill_we%0d", k), wr_en, 1);
      end
      in_instr = 32'h0000_BEEF;
      #1;
      check("fill_full", full, 1);
      check("fill_ready", in_ready, 0);
      check("fill_valid", valid_entries, 16'hFFFF);
      check("fill_occ", occupancy, 16);
      check("fill_last_instr", Instr_in, 32'h1000_000F);
      check("fill_last_alusrc", ALUSrc, 1);
      step();
      check("hold_we", wr_en, 0);
      check("hold_occ", occupancy, 16);

      // Release slots 3 and 7 while full: no accept that cycle.
      issue_mask[3] = 1'b1;
      issue_mask[7] = 1'b1;
      #1;
      check("rel_ready_full", in_ready, 0);
      step();
      issue_mask = '0;
      check("rel_we", wr_en, 0);
      check("rel_occ", occupancy, 14);
      check("rel_valid", valid_entries, 16'hEEFF);
      #1;
      check("rel_ready", in_ready, 1);
      step();
      check("reuse3_idx", buffer_index, 3);
      check("reuse3_instr", Instr_in, 32'h0000_BEEF);
      check("reuse3_we", wr_en, 1);
      in_instr = 32'h0000_C0DE;
      step();
      in_valid = 1'b0;
      check("reuse7_idx", buffer_index, 7);
      check("reuse7_instr", Instr_in, 32'h0000_C0DE);
      check("reuse_full", full, 1);

      // Same-cycle release and offer while full.
      issue_mask[5] = 1'b1;
      in_valid      = 1'b1;
      in_instr      = 32'h0000_5555;
      #1;
      check("sc_ready", in_ready, 0);
      step();
      issue_mask = '0;
      check("sc_we", wr_en, 0);
      check("sc_occ", occupancy, 15);
      check("sc_slot5", valid_entries[5], 0);
      step();
      in_valid = 1'b0;
      check("sc_we2", wr_en, 1);
      check("sc_idx", buffer_index, 5);
      check("sc_occ2", occupancy, 16);

      // Releasing an already-free slot is ignored.
      issue_mask[0] = 1'b1;
      step();
      check("rf_occ1", occupancy, 15);
      issue_mask[1] = 1'b1;
      step();
      issue_mask = '0;
      check("rf_occ2", occupancy, 14);
      check("rf_valid", valid_entries, 16'h3FFF);
      for (int s = 10; s <= 14; s++) issue_mask[s] = 1'b1;
      step();
      issue_mask = '0;
      check("pre_flush_occ", occupancy, 9);

      // Flush with an offered beat and a release in the same cycle.
      flush         = 1'b1;
      in_valid      = 1'b1;
      in_instr      = 32'h0000_F00D;
      issue_mask[2] = 1'b1;
      #1;
      check("fl_ready", in_ready, 0);
      step();
      flush      = 1'b0;
      in_valid   = 1'b0;
      issue_mask = '0;
      check("fl_valid", valid_entries, 16'h0000);
      check("fl_occ", occupancy, 0);
      check("fl_we", wr_en, 0);
      check("fl_empty", empty, 1);
      check("fl_instr_hold", Instr_in, 32'h0000_5555);
      step();
      check("fl_dropped_we", wr_en, 0);
      check("fl_dropped_occ", occupancy, 0);

      // Reset in the middle of a write burst.
      in_valid = 1'b1;
      in_instr = 32'h0000_7777;
      step();
      step();
      check("mr_idx_pre", buffer_index, 1);
      rst = 1'b0;
      step();
      check("mr_we", wr_en, 0);
      check("mr_idx", buffer_index, 0);
      check("mr_instr", Instr_in, 0);
      check("mr_occ", occupancy, 0);
      check("mr_valid", valid_entries, 16'h0000);
      rst      = 1'b1;
      in_valid = 1'b0;

`ifdef ESM_BUFFER_WRITER_AGE_EN
      in_valid = 1'b1;
      step();
      step();
      step();
      in_valid = 1'b0;
      check("age_ov0", oldest_valid, 1);
      check("age_oi0", oldest_index, 0);
      issue_mask[0] = 1'b1;
      step();
      issue_mask = '0;
      check("age_oi1", oldest_index, 1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      check("age_reuse_idx", buffer_index, 0);
      check("age_oi_reuse", oldest_index, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("age_fl_ov", oldest_valid, 0);
      check("age_fl_oi", oldest_index, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_esm_buffer_writer
